// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg -- shared definitions for the instruction/data memory arbiter.
//   State encoding (state_t, STATE_WD), bus width constants and the
//   fetch address alignment helper used by mem_arbiter.
package mem_arbiter_pkg;

  localparam int unsigned STATE_WD  = 3;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned LINE_W    = 64;
  localparam int unsigned STRB_W    = 4;
  localparam int unsigned STARVE_W  = 4;

  typedef enum logic [STATE_WD-1:0] {
    IDLE    = 3'd0,
    I_REQ0  = 3'd1,
    I_WAIT0 = 3'd2,
    I_REQ1  = 3'd3,
    I_WAIT1 = 3'd4,
    D_REQ   = 3'd5,
    D_WAIT  = 3'd6
  } state_t;

  // Fetches always start on a word boundary; the low two address bits are dropped.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- shared downstream memory request bus.
//   master : arbiter side (drives mem_req/mem_wr/mem_wstrb/mem_addr/mem_wdata,
//            receives mem_addr_ok/mem_data_ok/mem_rdata)
//   slave  : memory side (mirror image of master)
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              mem_req;
  logic              mem_wr;
  logic [STRB_W-1:0] mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_pick.sv
// mem_arb_pick -- fetch/data priority decision.
//   inst_req, data_req : pending requests
//   starve_cnt         : consecutive fetch losses so far
//   grant              : one-hot, grant[1] = fetch, grant[0] = data
// Data normally wins; once fetch has lost STARVE_MAX times in a row it wins.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                inst_req,
  input  logic                data_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic [1:0]          grant
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  always_comb begin
    grant = '0;
    if (inst_req && (!data_req || (starve_cnt >= STARVE_LIM))) begin
      grant = 2'b10;
    end else if (data_req) begin
      grant = 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- arbitrates a 64-bit instruction fetch port and a 32-bit
// load/store port onto one single-outstanding downstream memory bus.
//   clk, reset        : clock, synchronous active-high reset
//   inst_req/addr     : fetch request; inst_gnt accepts it
//   inst_rvalid/rdata : one-cycle pulse with {word@addr+4, word@addr}
//   data_req/wr/wstrb/addr/wdata : load/store request; data_gnt accepts it
//   data_rvalid/rdata : one-cycle completion pulse; rdata is 0 for stores
//   mem               : downstream bus (master side)
// A fetch is two back-to-back word reads; a data access is one transaction.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inst_req,
  input  logic [ADDR_W-1:0]  inst_addr,
  output logic               inst_gnt,
  output logic               inst_rvalid,
  output logic [LINE_W-1:0]  inst_rdata,
  input  logic               data_req,
  input  logic               data_wr,
  input  logic [STRB_W-1:0]  data_wstrb,
  input  logic [ADDR_W-1:0]  data_addr,
  input  logic [WORD_W-1:0]  data_wdata,
  output logic               data_gnt,
  output logic               data_rvalid,
  output logic [WORD_W-1:0]  data_rdata,
  mem_arbiter_if.master      mem
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [WORD_W-1:0]   lo_q;
  logic [STARVE_W-1:0] starve_q;

  logic [1:0]          pick;
  logic                idle;

  logic                req_c, wr_c;
  logic [STRB_W-1:0]   wstrb_c;
  logic [ADDR_W-1:0]   addr_c;
  logic [WORD_W-1:0]   wdata_c;
  logic                inst_rvalid_c, data_rvalid_c;
  logic [LINE_W-1:0]   inst_rdata_c;
  logic [WORD_W-1:0]   data_rdata_c;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .starve_cnt (starve_q),
    .grant      (pick)
  );

  // Grants are only possible in IDLE and are forced low while reset is held.
  assign idle     = (state_q == IDLE) && !reset;
  assign inst_gnt = idle && pick[1];
  assign data_gnt = idle && pick[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      lo_q     <= '0;
      starve_q <= '0;
    end else begin
      state_q <= state_d;
      if (inst_gnt) begin
        addr_q   <= word_align(inst_addr);
        wr_q     <= 1'b0;
        wstrb_q  <= '0;
        wdata_q  <= '0;
        starve_q <= '0;
      end else if (data_gnt) begin
        addr_q  <= data_addr;
        wr_q    <= data_wr;
        wstrb_q <= data_wstrb;
        wdata_q <= data_wdata;
        if (inst_req && (starve_q < STARVE_LIM)) begin
          starve_q <= starve_q + STARVE_W'(1);
        end
      end
      if ((state_q == I_WAIT0) && mem.mem_data_ok) begin
        lo_q <= mem.mem_rdata;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    req_c         = 1'b0;
    wr_c          = 1'b0;
    wstrb_c       = '0;
    addr_c        = '0;
    wdata_c       = '0;
    inst_rvalid_c = 1'b0;
    inst_rdata_c  = '0;
    data_rvalid_c = 1'b0;
    data_rdata_c  = '0;

    unique case (state_q)
      IDLE: begin
        if (inst_gnt) begin
          state_d = I_REQ0;
        end else if (data_gnt) begin
          state_d = D_REQ;
        end
      end
      I_REQ0: begin
        req_c  = 1'b1;
        addr_c = addr_q;
        if (mem.mem_addr_ok) state_d = I_WAIT0;
      end
      I_WAIT0: begin
        if (mem.mem_data_ok) state_d = I_REQ1;
      end
      I_REQ1: begin
        req_c  = 1'b1;
        addr_c = addr_q + ADDR_W'(4);
        if (mem.mem_addr_ok) state_d = I_WAIT1;
      end
      I_WAIT1: begin
        if (mem.mem_data_ok) begin
          inst_rvalid_c = 1'b1;
          inst_rdata_c  = {mem.mem_rdata, lo_q};
          state_d       = IDLE;
        end
      end
      D_REQ: begin
        req_c   = 1'b1;
        wr_c    = wr_q;
        wstrb_c = wstrb_q;
        addr_c  = addr_q;
        wdata_c = wdata_q;
        if (mem.mem_addr_ok) state_d = D_WAIT;
      end
      D_WAIT: begin
        if (mem.mem_data_ok) begin
          data_rvalid_c = 1'b1;
          data_rdata_c  = wr_q ? '0 : mem.mem_rdata;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output is forced to zero while reset is asserted, independent of
  // whatever state the register held before the reset edge.
  assign mem.mem_req   = req_c   && !reset;
  assign mem.mem_wr    = wr_c    && !reset;
  assign mem.mem_wstrb = reset ? '0 : wstrb_c;
  assign mem.mem_addr  = reset ? '0 : addr_c;
  assign mem.mem_wdata = reset ? '0 : wdata_c;
  assign inst_rvalid   = inst_rvalid_c && !reset;
  assign inst_rdata    = reset ? '0 : inst_rdata_c;
  assign data_rvalid   = data_rvalid_c && !reset;
  assign data_rdata    = reset ? '0 : data_rdata_c;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning consecutive fetch losses before fetch gets forced priority (legal range 1..15).
REQ-002 SHALL have one clock and a synchronous active-high reset; no other clock or reset.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 inst_req  in  1  fetch request.
REQ-006 inst_addr  in  32  fetch byte address; bits [1:0] ignored.
REQ-007 inst_gnt  out  1  fetch request accepted this cycle.
REQ-008 inst_rvalid  out  1  one-cycle pulse; inst_rdata valid.
REQ-009 inst_rdata  out  64  [31:0] = word at addr; [63:32] = word at addr+4.
REQ-010 data_req  in  1  load/store request.
REQ-011 data_wr, data_wstrb, data_addr, data_wdata  in  1/4/32/32  store flag, byte strobes, address, store data.
REQ-012 data_gnt  out  1  data request accepted this cycle.
REQ-013 data_rvalid  out  1  one-cycle completion pulse, for both loads and stores.
REQ-014 data_rdata  out  32  load data; 0 on stores.
REQ-015 mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata  out  1/1/4/32/32  shared downstream request.
REQ-016 mem_addr_ok, mem_data_ok  in  1/1  downstream address accept and response handshakes.
REQ-017 mem_rdata  in  32  downstream read data.

Function
REQ-018 SHALL implement the FSM states IDLE, I_REQ0, I_WAIT0, I_REQ1, I_WAIT1, D_REQ, D_WAIT.
REQ-019 SHALL accept a request only in IDLE; inst_gnt and data_gnt are combinational and are never both 1 in the same cycle.
REQ-020 On simultaneous requests in IDLE, SHALL grant data unless starve_cnt==STARVE_MAX, in which case it grants inst.
REQ-021 starve_cnt (4 bit):
- increments when inst_req is high and data is granted;
- clears on every inst grant;
- saturates at STARVE_MAX.
REQ-022 A grant in cycle T SHALL capture all request fields into registers, and mem_req SHALL be 1 from cycle T+1.
REQ-023 In each *_REQ state, mem_req SHALL be 1 and mem_* SHALL hold stable until mem_addr_ok; on mem_addr_ok the FSM moves to the matching *_WAIT state.
REQ-024 In *_WAIT states mem_req SHALL be 0; at most one downstream transaction is outstanding.
REQ-025 Fetch sequence:
- I_REQ0 issues a read of {addr[31:2],2'b00};
- on mem_data_ok in I_WAIT0, latches the low word and goes to I_REQ1;
- I_REQ1 issues a read of addr+4, mod 2^32;
- on mem_data_ok in I_WAIT1, pulses inst_rvalid with the 64-bit result and returns to IDLE.
REQ-026 Data sequence: D_REQ issues one access with mem_wr=data_wr and the captured strobes and data.
REQ-027 On mem_data_ok in D_WAIT, SHALL pulse data_rvalid, drive data_rdata=mem_rdata for loads and 0 for stores, and return to IDLE.
REQ-028 mem_wr=0 and mem_wstrb=0 SHALL hold for fetch reads.
REQ-029 mem_data_ok outside *_WAIT states SHALL be ignored.
REQ-030 The completion cycle SHALL return to IDLE and SHALL NOT grant a new request in that same cycle; the next grant is possible one cycle later.
REQ-031 Minimum fetch latency (addr_ok same cycle, data_ok next cycle) SHALL be gnt at T, rvalid at T+4.
REQ-032 Minimum data latency SHALL be gnt at T, rvalid at T+2.

Reset
REQ-033 With reset high at a clock edge, SHALL set the FSM to IDLE and starve_cnt=0.
REQ-034 With reset high, SHALL drive all outputs to 0, including inst_rdata and data_rdata.
REQ-035 Reset mid-transaction SHALL abandon the transaction with no rvalid pulse; the downstream slave shares the same reset.

Structure
REQ-036 State encoding, STATE_WD and the 32/64 width constants SHALL live in the shared defines header.
REQ-037 The priority decision (inputs: inst_req, data_req, starve_cnt, STARVE_MAX; outputs: one-hot grant) SHALL be one sub-module, mem_arb_pick.
REQ-038 The datapath registers and FSM SHALL be in mem_arbiter.

Verification
REQ-039 Fetch only: inst_addr=0xBFC00000, slave with addr_ok immediate and data_ok +1 returning 0x11111111 then 0x22222222 -> mem_addr 0xBFC00000 then 0xBFC00004; inst_rdata=0x2222222211111111 at T+4.
REQ-040 Wrap: inst_addr=0xFFFFFFFC -> second read at mem_addr 0x00000000.
REQ-041 Store: data_wr=1, wstrb=0x3, addr=0x80000010, wdata=0xDEADBEEF -> mem_wr=1, mem_wstrb=0x3; data_rvalid=1 with data_rdata=0 after data_ok.
REQ-042 Starvation, STARVE_MAX=4, data_req and inst_req held high -> four data grants, then an inst grant, then starve_cnt=0.
REQ-043 Stalled slave: addr_ok held low for 5 cycles in I_REQ1 -> mem_addr/mem_req stable for all 5 cycles; a spurious data_ok during I_REQ1 is ignored.
REQ-044 Reset in D_WAIT -> next cycle IDLE, all outputs 0, no data_rvalid; a fresh fetch then completes normally.
